axi_lite_pwm_slave: RTL

AXI_LITE_PWM_SLAVE -- requirements
Module: axi_lite_pwm_slave

---
 rtl/axi_pwm_pkg.sv | 39 +++
 rtl/pwm_core.sv | 61 ++++++
 rtl/axi_lite_pwm_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pwm_pkg
//  Purpose  : Shared constants and helpers for the AXI4-Lite PWM slave:
//             register word offsets, CTRL bit positions, response codes and
//             the byte-strobe merge used by the register write path.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_pwm_pkg;

  // Word index of each register (byte address bits [3:2])
  localparam logic [1:0] c_reg_ctrl   = 2'd0;
  localparam logic [1:0] c_reg_period = 2'd1;
  localparam logic [1:0] c_reg_duty   = 2'd2;
  localparam logic [1:0] c_reg_count  = 2'd3;

  // CTRL register bit positions
  localparam int c_ctrl_enable_bit = 0;
  localparam int c_ctrl_invert_bit = 1;

  // AXI response code; this slave never reports an error
  localparam logic [1:0] c_resp_okay = 2'b00;

  // Merge new write data into an old register value, one byte per strobe bit
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_val[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage : axi_pwm_pkg
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_core
//  Purpose  : Free-running period counter with shadowed PERIOD/DUTY values
//             and a registered PWM output with optional inversion.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_invert,
  input  logic [31:0] i_period,
  input  logic [31:0] i_duty,
  output logic [31:0] o_count,
  output logic        o_pwm
);

  logic [31:0] r_count;
  logic [31:0] r_period_act;
  logic [31:0] r_duty_act;
  logic        r_pwm;
  logic        w_wrap;
  logic        w_raw;

  // End of the current period: a zero period counts as wrapping every cycle,
  // which keeps the counter at 0 and lets a new PERIOD be picked up at once
  assign w_wrap = (r_period_act == 32'd0) || (r_count >= (r_period_act - 32'd1));

  // Raw compare; DUTY >= PERIOD naturally yields a constant high
  assign w_raw = i_enable && (r_period_act != 32'd0) && (r_count < r_duty_act);

  // Counter and shadow registers; shadows only reload at a period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 32'd0;
      r_period_act <= 32'd0;
      r_duty_act   <= 32'd0;
    end else if (!i_enable || w_wrap) begin
      r_count      <= 32'd0;
      r_period_act <= i_period;
      r_duty_act   <= i_duty;
    end else begin
      r_count      <= r_count + 32'd1;
    end
  end

  // Registered output stage, polarity applied here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_raw ^ i_invert;
    end
  end

  assign o_count = r_count;
  assign o_pwm   = r_pwm;

endmodule : pwm_core
`default_nettype wire

// File: rtl/axi_lite_pwm_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pwm_slave
//  Purpose  : AXI4-Lite slave with CTRL/PERIOD/DUTY/COUNT registers driving
//             a single PWM output through pwm_core.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_pwm_slave
  import axi_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_o
);

  logic [1:0]  r_ctrl;
  logic [31:0] r_period;
  logic [31:0] r_duty;
  logic        r_bvalid;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        w_wr_hs;
  logic        w_rd_hs;
  logic [1:0]  w_wr_idx;
  logic [1:0]  w_rd_idx;
  logic [31:0] w_wr_old;
  logic [31:0] w_wr_merged;
  logic [31:0] w_rd_data;
  logic [31:0] w_count;
  logic        w_unused;

  assign w_wr_idx = S_AXI_AWADDR[3:2];
  assign w_rd_idx = S_AXI_ARADDR[3:2];

  // Address and data are accepted together in one cycle; the ready is a
  // direct function of the valids so the write lands on the cycle both are up
  assign w_wr_hs = S_AXI_ARESETN && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
  assign w_rd_hs = S_AXI_ARESETN && S_AXI_ARVALID && !r_rvalid;

  assign S_AXI_AWREADY = w_wr_hs;
  assign S_AXI_WREADY  = w_wr_hs;
  assign S_AXI_ARREADY = w_rd_hs;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_BRESP   = c_resp_okay;
  assign S_AXI_RRESP   = c_resp_okay;

  // Protection bits and sub-word address bits carry no meaning here
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Current value of the addressed register, used as the strobe-merge base
  always_comb begin
    w_wr_old = 32'd0;
    case (w_wr_idx)
      c_reg_ctrl:   w_wr_old = {30'd0, r_ctrl};
      c_reg_period: w_wr_old = r_period;
      c_reg_duty:   w_wr_old = r_duty;
      default:      w_wr_old = 32'd0;
    endcase
  end

  assign w_wr_merged = apply_wstrb(w_wr_old, S_AXI_WDATA, S_AXI_WSTRB);

  // Read mux; CTRL upper bits read as zero, COUNT reflects the live counter
  always_comb begin
    w_rd_data = 32'd0;
    case (w_rd_idx)
      c_reg_ctrl:   w_rd_data = {30'd0, r_ctrl};
      c_reg_period: w_rd_data = r_period;
      c_reg_duty:   w_rd_data = r_duty;
      c_reg_count:  w_rd_data = w_count;
      default:      w_rd_data = 32'd0;
    endcase
  end

  // Register file update; writes to COUNT are acknowledged but discarded
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl   <= 2'd0;
      r_period <= 32'd0;
      r_duty   <= 32'd0;
    end else if (w_wr_hs) begin
      case (w_wr_idx)
        c_reg_ctrl:   r_ctrl   <= w_wr_merged[c_ctrl_invert_bit:c_ctrl_enable_bit];
        c_reg_period: r_period <= w_wr_merged;
        c_reg_duty:   r_duty   <= w_wr_merged;
        default:      ;
      endcase
    end
  end

  // Write response: raised after the handshake, held until the master takes it
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bvalid <= 1'b0;
    end else if (w_wr_hs) begin
      r_bvalid <= 1'b1;
    end else if (S_AXI_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read data channel: capture on address handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (w_rd_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  pwm_core u_pwm_core (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .i_enable (r_ctrl[c_ctrl_enable_bit]),
    .i_invert (r_ctrl[c_ctrl_invert_bit]),
    .i_period (r_period),
    .i_duty   (r_duty),
    .o_count  (w_count),
    .o_pwm    (pwm_o)
  );

endmodule : axi_lite_pwm_slave
`default_nettype wire
